pcpu_mem_sys: RTL and testbench

Memory-side responder for the 16-bit pipeline processor. It holds the 256x16 instruction memory and the 256x16 data memory. It answers the processor's instruction-fetch and load/store accesses with the timing the pipeline expects. A byte-stream host loader FSM fills either memory while the processor is held, then releases it.

---
 rtl/pcpu_mem_sys.sv | 157 +++++++++++++++
 tb/tb_pcpu_mem_sys.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pcpu_mem_sys.sv
// Instruction/data memories for the 16-bit pipeline CPU plus a byte-stream host loader.
// Optional PCPU_MEM_CHECKSUM_EN adds ld_sum, the mod-2**DW sum of words written by the loader.
module pcpu_mem_sys #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned LEN_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    i_addr,
  output logic [DW-1:0]    i_dataout,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  input  logic             d_we,
  output logic [DW-1:0]    d_rdata,
  input  logic             h_start,
  input  logic             h_target,
  input  logic [AW-1:0]    h_base,
  input  logic [LEN_W-1:0] h_len,
  input  logic             h_valid,
  input  logic [7:0]       h_data,
  output logic             h_ready,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic             wr_err
`ifdef PCPU_MEM_CHECKSUM_EN
  ,
  output logic [DW-1:0]    ld_sum
`endif
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] word_q, word_d;
  logic [7:0]       hi_q, hi_d;
  logic             tgt_q, tgt_d;
  logic             wr_err_q, wr_err_d;
  logic             host_we_c;
  logic [DW-1:0]    host_wdata_c;

  logic [DW-1:0] imem_q [DEPTH];
  logic [DW-1:0] dmem_q [DEPTH];

  // Loader FSM next-state and datapath
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    hi_d      = hi_q;
    tgt_d     = tgt_q;
    host_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (h_start) begin
          tgt_d   = h_target;
          addr_d  = h_base;
          word_d  = h_len;
          state_d = (h_len == '0) ? FIN : HI;
        end
      end
      HI: begin
        if (h_valid) begin
          hi_d    = h_data;
          state_d = LO;
        end
      end
      LO: begin
        if (h_valid) begin
          host_we_c = 1'b1;
          addr_d    = addr_q + AW'(1);
          word_d    = word_q - LEN_W'(1);
          state_d   = (word_q == LEN_W'(1)) ? FIN : HI;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign host_wdata_c = DW'({hi_q, h_data});
  assign h_ready      = (state_q == HI) || (state_q == LO);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign cpu_enable   = ~busy;
  assign wr_err       = wr_err_q;
  assign wr_err_d     = wr_err_q | (d_we & busy);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      word_q   <= '0;
      hi_q     <= '0;
      tgt_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      hi_q     <= hi_d;
      tgt_q    <= tgt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Memories are never reset; host writes win over processor stores
  always_ff @(posedge clock) begin
    if (host_we_c && !tgt_q) begin
      imem_q[addr_q] <= host_wdata_c;
    end
  end

  always_ff @(posedge clock) begin
    if (host_we_c && tgt_q) begin
      dmem_q[addr_q] <= host_wdata_c;
    end else if (d_we && !busy) begin
      dmem_q[d_addr] <= d_wdata;
    end
  end

  assign i_dataout = imem_q[i_addr];
  assign d_rdata   = dmem_q[d_addr];

`ifdef PCPU_MEM_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && h_start) begin
      sum_d = '0;
    end else if (host_we_c) begin
      sum_d = sum_q + host_wdata_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign ld_sum = sum_q;
`endif

endmodule

// File: tb/tb_pcpu_mem_sys.sv
// Directed bench for pcpu_mem_sys: loader sessions, processor stores, and a memory read-back table.
module tb_pcpu_mem_sys;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_addr, d_addr, h_base;
  logic [15:0] i_dataout, d_rdata, d_wdata;
  logic        d_we, h_start, h_target, h_valid;
  logic [8:0]  h_len;
  logic [7:0]  h_data;
  logic        h_ready, busy, done, cpu_enable, wr_err;
`ifdef PCPU_MEM_CHECKSUM_EN
  logic [15:0] ld_sum;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_snap;

  typedef struct {
    string       name;
    logic        is_d;
    logic [7:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab [10];

  pcpu_mem_sys dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_dataout(i_dataout),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_rdata(d_rdata),
    .h_start(h_start), .h_target(h_target), .h_base(h_base), .h_len(h_len),
    .h_valid(h_valid), .h_data(h_data), .h_ready(h_ready),
    .busy(busy), .done(done), .cpu_enable(cpu_enable), .wr_err(wr_err)
`ifdef PCPU_MEM_CHECKSUM_EN
    , .ld_sum(ld_sum)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (done) done_cnt++;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic tgt, input logic [7:0] base, input logic [8:0] len);
    h_start = 1'b1; h_target = tgt; h_base = base; h_len = len;
    tick();
    h_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = $urandom_range(0, 2);
    h_valid = 1'b0;
    repeat (gap) tick();
    h_valid = 1'b1; h_data = b;
    n = 0;
    while (!h_ready && n < 20) begin
      tick();
      n++;
    end
    check("h_ready_wait", 16'(h_ready), 16'd1);
    check("cpu_en_low_in_session", 16'(cpu_enable), 16'd0);
    tick();
    h_valid = 1'b0;
  endtask

  initial begin
    rd_tab[0] = '{"imem_10", 1'b0, 8'h10, 16'h1234};
    rd_tab[1] = '{"imem_11", 1'b0, 8'h11, 16'hABCD};
    rd_tab[2] = '{"dmem_ff_wrap", 1'b1, 8'hFF, 16'h0001};
    rd_tab[3] = '{"dmem_00_wrap", 1'b1, 8'h00, 16'h0002};
    rd_tab[4] = '{"dmem_30_no_collide", 1'b1, 8'h30, 16'h7777};
    rd_tab[5] = '{"dmem_20_store", 1'b1, 8'h20, 16'h5A5A};
    rd_tab[6] = '{"imem_40_kept", 1'b0, 8'h40, 16'h1111};
    rd_tab[7] = '{"dmem_50", 1'b1, 8'h50, 16'h1234};
    rd_tab[8] = '{"dmem_51", 1'b1, 8'h51, 16'hABCD};
    rd_tab[9] = '{"dmem_80_ignored_start", 1'b1, 8'h80, 16'h4242};

    reset = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    h_start = 1'b0; h_target = 1'b0; h_base = '0; h_len = '0;
    h_valid = 1'b0; h_data = '0;
    #12;
    check("rst_h_ready", 16'(h_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_cpu_enable", 16'(cpu_enable), 16'd1);
    check("rst_wr_err", 16'(wr_err), 16'd0);
`ifdef PCPU_MEM_CHECKSUM_EN
    check("rst_ld_sum", ld_sum, 16'h0000);
`endif
    reset = 1'b1;
    tick();

    // Processor stores: seed known values, then store-then-load timing
    d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1111; tick();
    d_addr = 8'h30; d_wdata = 16'h7777; tick();
    d_addr = 8'h80; d_wdata = 16'h4242; tick();
    d_addr = 8'h20; d_wdata = 16'h5A5A;
    #1;
    check("store_old_same_cycle", d_rdata, 16'h1111);
    tick();
    d_we = 1'b0;
    check("store_new_next_cycle", d_rdata, 16'h5A5A);

    // Instruction load with random valid gaps
    done_snap = done_cnt;
    start(1'b0, 8'h10, 9'd2);
    check("iload_busy", 16'(busy), 16'd1);
    check("iload_cpu_en", 16'(cpu_enable), 16'd0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    check("iload_fin_done", 16'(done), 16'd1);
    check("iload_fin_busy", 16'(busy), 16'd1);
    tick();
    check("iload_idle_done", 16'(done), 16'd0);
    check("iload_idle_cpu_en", 16'(cpu_enable), 16'd1);
    check("iload_done_pulses", 16'(done_cnt - done_snap), 16'd1);
    i_addr = 8'h11; #1;
    check("iload_fetch_11", i_dataout, 16'hABCD);
    check("wr_err_clean", 16'(wr_err), 16'd0);

    // Data load across the wrap with a colliding store and an ignored h_start
    start(1'b1, 8'hFF, 9'd2);
    send_byte(8'h00);
    d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'hDEAD;
    h_start = 1'b1; h_target = 1'b1; h_base = 8'h80; h_len = 9'd1;
    tick();
    d_we = 1'b0; h_start = 1'b0;
    check("collide_wr_err", 16'(wr_err), 16'd1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    check("wrap_fin_done", 16'(done), 16'd1);
    tick();
    check("wrap_idle_busy", 16'(busy), 16'd0);
    repeat (3) tick();
    check("wr_err_sticky", 16'(wr_err), 16'd1);

    // Zero-length session: one FIN cycle, no writes
    done_snap = done_cnt;
    start(1'b0, 8'h10, 9'd0);
    check("zlen_busy", 16'(busy), 16'd1);
    check("zlen_done", 16'(done), 16'd1);
    check("zlen_h_ready", 16'(h_ready), 16'd0);
    tick();
    check("zlen_idle", 16'(busy), 16'd0);
    check("zlen_done_pulses", 16'(done_cnt - done_snap), 16'd1);

    // Reset after one word and one high byte
    start(1'b0, 8'h40, 9'd3);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22);
    check("midrst_busy_before", 16'(busy), 16'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_cpu_en", 16'(cpu_enable), 16'd1);
    check("midrst_h_ready", 16'(h_ready), 16'd0);
    check("midrst_wr_err", 16'(wr_err), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Full data session, used for the checksum
    start(1'b1, 8'h50, 9'd2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    check("cs_fin_done", 16'(done), 16'd1);
    tick();
`ifdef PCPU_MEM_CHECKSUM_EN
    check("ld_sum", ld_sum, 16'hBE01);
    repeat (2) tick();
    check("ld_sum_hold", ld_sum, 16'hBE01);
`endif

    for (int i = 0; i < 10; i++) begin
      if (rd_tab[i].is_d) begin
        d_addr = rd_tab[i].addr; #1;
        check(rd_tab[i].name, d_rdata, rd_tab[i].exp);
      end else begin
        i_addr = rd_tab[i].addr; #1;
        check(rd_tab[i].name, i_dataout, rd_tab[i].exp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
